mcpu_mem_bridge: RTL and testbench

MCPU_MEM_BRIDGE -- requirements
Module: mcpu_mem_bridge

---
 rtl/mcpu_mem_pkg.sv | 17 +
 rtl/mcpu_mem_timeout.sv | 36 +++
 rtl/mcpu_mem_bridge.sv | 189 ++++++++++++++++++
 tb/tb_mcpu_mem_bridge.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_mem_pkg.sv
// Shared types and constants for the CPU-to-memory bridge.
package mcpu_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Value cpu_rdata takes out of reset.
    localparam logic [DATA_W-1:0] RDATA_RST = '0;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        DONE
    } state_e;

endpackage

// File: rtl/mcpu_mem_timeout.sv
// Per-transaction watchdog: 8-bit counter with clear, count-enable and an
// expire flag that is raised on the TIMEOUT-th enabled cycle.
module mcpu_mem_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    // Clear wins over count; saturate so a stuck enable can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // The cycle holding count TIMEOUT-1 is the last one allowed.
    assign expire = en && (cnt_q >= LIMIT);

endmodule

// File: rtl/mcpu_mem_bridge.sv
// CPU-to-memory bridge: turns a level CPU request into a valid/ready memory
// request plus an optional read response, with alignment and timeout errors.
// Optional one-entry posted-write buffer: define MCPU_MEM_WRITE_BUFFER_EN.
module mcpu_mem_bridge
    import mcpu_mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              cpu_stall,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e              state_q, state_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_valid_q, mem_valid_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                to_clr, to_en, to_expire;
    logic                buf_busy;

`ifdef MCPU_MEM_WRITE_BUFFER_EN
    // buf_q: a posted write is still draining on the memory channel.
    // pend_err_q: a drain timed out; reported on the next completion.
    logic buf_q, buf_d;
    logic pend_err_q, pend_err_d;
    assign buf_busy = buf_q;
`else
    assign buf_busy = 1'b0;
`endif

    // One watchdog serves both the FSM and the write drain; they never overlap
    // because IDLE refuses new requests while the buffer is occupied.
    mcpu_mem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clr    (to_clr),
        .en     (to_en),
        .expire (to_expire)
    );

    // Next-state, request-channel and completion-status logic.
    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        to_clr      = 1'b0;
        to_en       = 1'b0;
`ifdef MCPU_MEM_WRITE_BUFFER_EN
        buf_d       = buf_q;
        pend_err_d  = pend_err_q;
        if (buf_q) begin
            to_en = 1'b1;
            if (mem_ready) begin
                mem_valid_d = 1'b0;
                buf_d       = 1'b0;
            end else if (to_expire) begin
                mem_valid_d = 1'b0;
                buf_d       = 1'b0;
                pend_err_d  = 1'b1;
            end
        end
`endif
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (cpu_req && !buf_busy) begin
                    if (cpu_addr[1:0] != 2'b00) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_we_d    = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                        to_clr      = 1'b1;
                        state_d     = REQ;
`ifdef MCPU_MEM_WRITE_BUFFER_EN
                        // Posted write: complete now, drain in the background.
                        if (cpu_we) begin
                            buf_d   = 1'b1;
                            state_d = DONE;
                        end
`endif
                    end
                end
            end
            REQ: begin
                // A handshake in the expiring cycle still counts as accepted.
                to_en = 1'b1;
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = mem_we_q ? DONE : WAIT_R;
                end else if (to_expire) begin
                    mem_valid_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = DONE;
                end
            end
            WAIT_R: begin
                to_en = 1'b1;
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                end else if (to_expire) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef MCPU_MEM_WRITE_BUFFER_EN
                pend_err_d = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
`ifdef MCPU_MEM_WRITE_BUFFER_EN
        if (state_d == DONE && state_q != DONE) begin
            err_d = err_d | pend_err_q;
        end
`endif
    end

    // State and request-channel registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            err_q       <= 1'b0;
            rdata_q     <= RDATA_RST;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef MCPU_MEM_WRITE_BUFFER_EN
    // Posted-write buffer status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q      <= 1'b0;
            pend_err_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            pend_err_q <= pend_err_d;
        end
    end
`endif

    assign cpu_done  = (state_q == DONE);
    assign cpu_err   = cpu_done && err_q;
    // Gated by reset so every output reads 0 while reset is held.
    assign cpu_stall = reset && cpu_req && !cpu_done;
    assign cpu_rdata = rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mcpu_mem_bridge.sv
// Scoreboard bench for mcpu_mem_bridge (default build, TIMEOUT=4).
module tb_mcpu_mem_bridge;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_done, cpu_err, cpu_stall;
    logic        mem_valid, mem_we;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    mcpu_mem_bridge #(.TIMEOUT(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_done   (cpu_done),
        .cpu_err    (cpu_err),
        .cpu_stall  (cpu_stall),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          mis;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        int          done_cyc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          n_done = 0;
    logic [31:0] last_rdata = '0;
    int          dr_cfg = 0;   // mem_valid cycles before mem_ready
    int          dv_cfg = 0;   // cycles after accept before mem_rvalid
    logic [31:0] rd_val = '0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference outcome. Cycle 0 is the one in which the request is sampled;
    // the bridge then spends cycles i=0,1,.. in its request/response phase and
    // gives up at the end of cycle T-1 of that phase unless the awaited event
    // (accept, or read data once accepted) arrives in that same cycle.
    function automatic void predict(input bit we, input logic [31:0] addr,
                                    input int dr, input int dv,
                                    output bit err, output int lat, output bit rd_ok);
        int ie;
        rd_ok = 1'b0;
        if (addr[1:0] != 2'b00) begin
            err = 1'b1; lat = 1;
        end else if (dr > T - 1) begin
            err = 1'b1; lat = T + 1;
        end else if (we) begin
            err = 1'b0; lat = dr + 2;
        end else begin
            ie = (T - 1 > dr + 1) ? T - 1 : dr + 1;
            if (dr + 1 + dv <= ie) begin
                err = 1'b0; lat = dr + dv + 3; rd_ok = 1'b1;
            end else begin
                err = 1'b1; lat = ie + 2;
            end
        end
    endfunction

    // Call at posedge+1 of a cycle in which the bridge is idle.
    task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rv, input int dr, input int dv);
        exp_t e;
        bit   err, ok;
        int   lat;
        predict(we, addr, dr, dv, err, lat, ok);
        dr_cfg = dr; dv_cfg = dv; rd_val = rv;
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        if (ok) last_rdata = rv;
        e.mis      = (addr[1:0] != 2'b00);
        e.we       = we;
        e.addr     = addr;
        e.wdata    = wdata;
        e.rdata    = last_rdata;
        e.err      = err;
        e.done_cyc = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst cpu_done",  65'(cpu_done),  65'(0));
        chk("rst cpu_err",   65'(cpu_err),   65'(0));
        chk("rst cpu_stall", 65'(cpu_stall), 65'(0));
        chk("rst cpu_rdata", 65'(cpu_rdata), 65'(0));
        chk("rst mem_valid", 65'(mem_valid), 65'(0));
        chk("rst mem_req",   {mem_we, mem_addr, mem_wdata}, 65'(0));
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        last_rdata = '0;
        reset = 1'b1;
    endtask

    // Returns at posedge+1 of the idle cycle following cpu_done.
    task automatic wait_done();
        int start;
        bit got;
        start = n_done;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (n_done != start) got = 1'b1;
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL completion: no cpu_done within 40 cycles");
            do_reset();
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_gap();
        int k;
        cpu_req = 1'b0;
        k = int'($urandom_range(1, 3));
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic rand_txn();
        bit          we;
        logic [31:0] a;
        int          dr, dv;
        we = 1'($urandom_range(0, 1));
        a  = $urandom;
        if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
        dr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(3, 6)) : int'($urandom_range(0, 2));
        dv = int'($urandom_range(0, 3));
        issue(we, a, $urandom, $urandom, dr, dv);
        wait_done();
        if ($urandom_range(0, 2) != 0) idle_gap();
    endtask

    // Memory model: mem_ready after dr_cfg cycles of mem_valid, read data
    // dv_cfg cycles after the accept, plus stray mem_rvalid pulses elsewhere.
    initial begin
        int vcnt, rcnt;
        bit rpend;
        vcnt = 0; rcnt = 0; rpend = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                vcnt = 0; rpend = 1'b0;
                mem_ready = 1'b0; mem_rvalid = 1'b0;
            end else begin
                mem_rvalid = 1'b0;
                if (rpend && (rcnt == dv_cfg || cpu_done)) begin
                    mem_rvalid = 1'b1; mem_rdata = rd_val; rpend = 1'b0;
                end else if (rpend) begin
                    rcnt++;
                end else if ($urandom_range(0, 7) == 0) begin
                    mem_rvalid = 1'b1; mem_rdata = $urandom;
                end
                if (mem_valid) begin
                    mem_ready = (vcnt == dr_cfg);
                    if (mem_ready && !mem_we) begin
                        rpend = 1'b1; rcnt = 0;
                    end
                    vcnt++;
                end else begin
                    vcnt = 0; mem_ready = 1'b0;
                end
            end
        end
    end

    // Monitor: checks the request channel and pops the scoreboard on cpu_done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("cpu_stall", 65'(cpu_stall), 65'(cpu_req && !cpu_done));
                if (!cpu_done) chk("cpu_err without done", 65'(cpu_err), 65'(0));
                if (mem_valid) begin
                    if (sb.size() == 0 || sb[0].mis) begin
                        chk("unexpected mem_valid", 65'(mem_valid), 65'(0));
                    end else begin
                        chk("mem req fields", {mem_we, mem_addr, mem_wdata},
                            {sb[0].we, sb[0].addr, sb[0].wdata});
                    end
                end
                if (cpu_done) begin
                    n_done++;
                    if (sb.size() == 0) begin
                        chk("unexpected cpu_done", 65'(cpu_done), 65'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("cpu_err",    65'(cpu_err),   65'(e.err));
                        chk("cpu_rdata",  65'(cpu_rdata), 65'(e.rdata));
                        chk("done cycle", 65'(cyc),       65'(e.done_cyc));
                    end
                end
            end
        end
    end

    // Stimulus: directed cases, back-to-back, random, reset mid-read.
    initial begin
        #3;
        do_reset();

        // Zero-wait read.
        issue(1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 0, 0);
        wait_done();
        idle_gap();
        // Write with mem_ready held off for three cycles.
        issue(1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, 3, 0);
        wait_done();
        idle_gap();
        // Misaligned read and write.
        issue(1'b0, 32'h0000_0102, 32'h0, 32'h1111_1111, 0, 0);
        wait_done();
        idle_gap();
        issue(1'b1, 32'h0000_0041, 32'hAAAA_5555, 32'h0, 0, 0);
        wait_done();
        idle_gap();
        // Request never accepted: timeout, rdata kept.
        issue(1'b0, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF, 9, 0);
        wait_done();
        idle_gap();
        // Accepted but read data too late: timeout, late rvalid ignored.
        issue(1'b0, 32'h0000_0204, 32'h0, 32'hDEAD_BEEF, 0, 9);
        wait_done();
        idle_gap();
        // Back-to-back with cpu_req held through DONE.
        issue(1'b1, 32'h0000_0300, 32'h0BAD_CAFE, 32'h0, 1, 0);
        wait_done();
        issue(1'b0, 32'h0000_0304, 32'h0, 32'h7777_0001, 0, 1);
        wait_done();
        issue(1'b0, 32'h0000_0308, 32'h0, 32'h7777_0002, 1, 0);
        wait_done();
        idle_gap();

        for (int n = 0; n < 150; n++) rand_txn();
        idle_gap();

        // Reset while waiting for read data, then a normal read.
        issue(1'b0, 32'h0000_0400, 32'h0, 32'h5555_AAAA, 0, 20);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        issue(1'b0, 32'h0000_0404, 32'h0, 32'h0F0F_1234, 1, 1);
        wait_done();
        idle_gap();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
